spi_slave_shift: RTL and testbench
==================================

Name: spi_slave_shift

Overview:
SPI target (slave) serial engine: the receiving end of the SPI master built around the clock generator. It oversamples the master's SCLK, SS_N and MOSI pins in the wb_clk_in domain and assembles received characters. It shifts transmit characters out on MISO, loaded through a one-entry valid/ready transmit buffer. Supports all four CPOL/CPHA modes, full-duplex, with back-to-back characters while SS_N is held low.

Parameters:
CHAR_LEN, 8, bits per character (2..32)
SYNC_STAGES, 2, synchronizer flops per input pin (>=2)

Ports:
wb_clk_in  input  1  system clock; all logic on rising edge
wb_rst  input  1  asynchronous, active-low reset (asserted when 0)
cpol  input  1  SCLK idle level; static while ss_n_in high
cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; static while ss_n_in high
sclk_in  input  1  SCLK from master, asynchronous
ss_n_in  input  1  slave select, active low, asynchronous
mosi_in  input  1  serial data from master
miso_out  output  1  serial data to master
miso_oe  output  1  MISO output enable
tx_data  input  CHAR_LEN  character to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  transmit buffer empty
rx_data  output  CHAR_LEN  last received character, held until next
rx_valid  output  1  one-cycle pulse, rx_data updated
tx_underrun  output  1  one-cycle pulse, load found buffer empty
busy  output  1  selected (ACTIVE state)

Behaviour:
- Reset (wb_rst=0): sclk sync chain and s_sclk = 0; ss_n chain and s_ss_n = 1; state IDLE; bit_cnt=0; tx_sr=0; tx_buf empty; rx_data=0; rx_valid=0; tx_underrun=0; tx_ready=1; busy=0; miso_oe=0; miso_out=0.
- Synchronizers: SYNC_STAGES flops per pin. One extra flop on s_sclk gives edge detect. Pin edge to internal action = SYNC_STAGES+1 cycles. The master's SCLK high and low phases must each be >= 4 wb_clk_in cycles.
- Edges: leading = s_sclk leaves cpol; trailing = s_sclk returns to cpol. Sample edge = leading if cpha=0, else trailing. Shift edge = the other edge.
- States: IDLE -> ACTIVE on s_ss_n falling. ACTIVE -> IDLE on s_ss_n rising.
- IDLE->ACTIVE: bit_cnt=0. If cpha=0, perform a load (below).
- Load: if tx_buf full, tx_sr<=tx_buf and the buffer empties. Else tx_sr<=0 and tx_underrun pulses.
- Sample edge (ACTIVE): rx_sr <= {rx_sr[CHAR_LEN-2:0], s_mosi}; bit_cnt++. When bit_cnt was CHAR_LEN-1: rx_data <= assembled character (including the current bit), rx_valid=1 for one cycle, bit_cnt wraps to 0.
- Shift edge (ACTIVE): if bit_cnt==0, load; else tx_sr <= tx_sr<<1.
  - This covers cpha=1 first edge of each character and cpha=0 after each completed character.
- miso_out = tx_sr[CHAR_LEN-1]. miso_oe = busy.
- Transmit buffer: accepted when tx_valid && tx_ready; tx_ready = buffer empty.
  - Accept and load in the same cycle: a load takes the old contents (or underruns if empty); the new data enters the buffer. No bypass.
- No receive handshake: the consumer must capture rx_data within CHAR_LEN SCLK periods.
- ss_n rise mid-character: partial character discarded, no rx_valid, bit_cnt=0, tx_sr=0. tx_buf is not affected.
- Edges while IDLE are ignored.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
SPI_SLV_LSB_FIRST_EN
- Defined: LSB-first. miso_out = tx_sr[0]; shift is tx_sr>>1; rx shifts right, inserting s_mosi at bit CHAR_LEN-1.
- Undefined: MSB-first as described above.

Test Plan:
- Mode 0 (cpol=0, cpha=0), tx_buf=0xA5 before select, master sends 0x3C at SCLK=wb_clk_in/8 -> rx_valid once, rx_data=0x3C; MISO bits captured by master = 0xA5; tx_ready back to 1 after the select-time load.
- Mode 3 (cpol=1, cpha=1), two back-to-back characters: MOSI 0x81, 0x7E; tx 0x12 then 0x34 supplied when tx_ready rises -> rx_valid twice with 0x81 then 0x7E; master receives 0x12, 0x34; no tx_underrun.
- Mode 1 with tx buffer empty at first shift edge -> tx_underrun one pulse, MISO all zeros; rx still correct (0xC3 -> rx_data=0xC3).
- ss_n deasserted after 5 of 8 bits -> no rx_valid, busy=0, miso_oe=0; next full transfer of 0x55 -> rx_data=0x55.
- wb_rst asserted low mid-character -> all outputs at reset values on the same cycle; after release, mode 2 transfer of 0xF0 -> rx_data=0xF0.
- With SPI_SLV_LSB_FIRST_EN defined, mode 0, MOSI bit order 1,0,0,0,0,0,0,0 -> rx_data=0x01; tx 0x01 -> first MISO bit 1.

Source files
------------

// File: rtl/spi_slave_shift.sv
// spi_slave_shift: SPI target serial engine.
// Oversamples SCLK, SS_N and MOSI in the wb_clk_in domain, assembles received
// characters and shifts transmit characters out on MISO from a one-entry
// valid/ready transmit buffer. Supports all four CPOL/CPHA modes.
// Optional build macro SPI_SLV_LSB_FIRST_EN selects LSB-first bit order;
// without it characters travel MSB-first.
module spi_slave_shift #(
  parameter int CHAR_LEN    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                wb_clk_in,
  input  logic                wb_rst,
  input  logic                cpol,
  input  logic                cpha,
  input  logic                sclk_in,
  input  logic                ss_n_in,
  input  logic                mosi_in,
  output logic                miso_out,
  output logic                miso_oe,
  input  logic [CHAR_LEN-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [CHAR_LEN-1:0] rx_data,
  output logic                rx_valid,
  output logic                tx_underrun,
  output logic                busy
);

  localparam int CNT_W = (CHAR_LEN > 1) ? $clog2(CHAR_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAR_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Synchronizer chains and the extra SCLK flop used for edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   s_sclk;
  logic                   s_ss_n;
  logic                   s_mosi;

  // Edge classification
  logic sclk_rise;
  logic sclk_fall;
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;

  // Control state
  state_t state_q;
  logic   busy_q;
  logic   go_active;
  logic   go_idle;
  logic   act;
  logic   load;

  // Datapath registers
  logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;
  logic [CHAR_LEN-1:0] tx_sr_q,     tx_sr_d;
  logic [CHAR_LEN-1:0] rx_sr_q,     rx_sr_d;
  logic [CHAR_LEN-1:0] rx_data_q,   rx_data_d;
  logic                rx_valid_q,  rx_valid_d;
  logic                underrun_q,  underrun_d;
  logic [CHAR_LEN-1:0] buf_q,       buf_d;
  logic                buf_full_q,  buf_full_d;

  // Bit-order dependent shift results
  logic [CHAR_LEN-1:0] rx_next;
  logic [CHAR_LEN-1:0] tx_shifted;
  logic                tx_out_bit;

  // Bring the asynchronous pins into the clock domain and keep last SCLK
  always_ff @(posedge wb_clk_in or negedge wb_rst) begin
    if (!wb_rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_in};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
      sclk_prev_q <= s_sclk;
    end
  end

  assign s_sclk = sclk_sync_q[SYNC_STAGES-1];
  assign s_ss_n = ss_sync_q[SYNC_STAGES-1];
  assign s_mosi = mosi_sync_q[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it
  always_comb begin
    sclk_rise   = s_sclk & ~sclk_prev_q;
    sclk_fall   = ~s_sclk & sclk_prev_q;
    lead_edge   = cpol ? sclk_fall : sclk_rise;
    trail_edge  = cpol ? sclk_rise : sclk_fall;
    sample_edge = cpha ? trail_edge : lead_edge;
    shift_edge  = cpha ? lead_edge : trail_edge;
  end

  assign go_active = (state_q == IDLE) && !s_ss_n;
  assign go_idle   = (state_q == ACTIVE) && s_ss_n;
  assign act       = (state_q == ACTIVE) && !s_ss_n;

  // A load happens on selection in cpha=0, and on the first shift edge of each character
  assign load = (go_active && !cpha) ||
                (act && shift_edge && (bit_cnt_q == '0));

`ifdef SPI_SLV_LSB_FIRST_EN
  assign rx_next    = {s_mosi, rx_sr_q[CHAR_LEN-1:1]};
  assign tx_shifted = {1'b0, tx_sr_q[CHAR_LEN-1:1]};
  assign tx_out_bit = tx_sr_q[0];
`else
  assign rx_next    = {rx_sr_q[CHAR_LEN-2:0], s_mosi};
  assign tx_shifted = {tx_sr_q[CHAR_LEN-2:0], 1'b0};
  assign tx_out_bit = tx_sr_q[CHAR_LEN-1];
`endif

  // Select/deselect state machine with registered busy flag
  always_ff @(posedge wb_clk_in or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!s_ss_n) begin
            state_q <= ACTIVE;
            busy_q  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (s_ss_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Next-state logic for counters, shift registers and the transmit buffer
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;

    if (go_active) begin
      bit_cnt_d = '0;
    end

    if (go_idle) begin
      bit_cnt_d = '0;
      tx_sr_d   = '0;
      rx_sr_d   = '0;
    end

    if (act && sample_edge) begin
      rx_sr_d = rx_next;
      if (bit_cnt_q == CNT_LAST) begin
        rx_data_d  = rx_next;
        rx_valid_d = 1'b1;
        bit_cnt_d  = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_ONE;
      end
    end

    if (act && shift_edge && (bit_cnt_q != '0)) begin
      tx_sr_d = tx_shifted;
    end

    // Loads always see the buffer contents from before this cycle's accept
    if (load) begin
      if (buf_full_q) begin
        tx_sr_d    = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_sr_d    = '0;
        underrun_d = 1'b1;
      end
    end

    if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end
  end

  // Register the datapath
  always_ff @(posedge wb_clk_in or negedge wb_rst) begin
    if (!wb_rst) begin
      bit_cnt_q  <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end

  assign miso_out    = tx_out_bit;
  assign miso_oe     = busy_q;
  assign busy        = busy_q;
  assign tx_ready    = !buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_shift.sv
// tb_spi_slave_shift: directed bench for spi_slave_shift acting as an SPI master.
// Honors SPI_SLV_LSB_FIRST_EN for the bit-order test.
module tb_spi_slave_shift;

  localparam int CL = 8;
  localparam int H  = 4;

  logic          clk     = 1'b0;
  logic          rstN    = 1'b0;
  logic          cpol    = 1'b0;
  logic          cpha    = 1'b0;
  logic          sclk    = 1'b0;
  logic          ssN     = 1'b1;
  logic          mosi    = 1'b0;
  logic [CL-1:0] txData  = '0;
  logic          txValid = 1'b0;
  logic          misoOut;
  logic          misoOe;
  logic          txReady;
  logic [CL-1:0] rxData;
  logic          rxValid;
  logic          txUnderrun;
  logic          busy;

  int            testsRun      = 0;
  int            testsFailed   = 0;
  int            rxCount       = 0;
  int            underrunCount = 0;
  logic [CL-1:0] rxLog[$];
  logic [CL-1:0] txq[$];
  logic [CL-1:0] cap0;
  logic [CL-1:0] cap1;

  spi_slave_shift #(.CHAR_LEN(CL), .SYNC_STAGES(2)) dut (
    .wb_clk_in   (clk),
    .wb_rst      (rstN),
    .cpol        (cpol),
    .cpha        (cpha),
    .sclk_in     (sclk),
    .ss_n_in     (ssN),
    .mosi_in     (mosi),
    .miso_out    (misoOut),
    .miso_oe     (misoOe),
    .tx_data     (txData),
    .tx_valid    (txValid),
    .tx_ready    (txReady),
    .rx_data     (rxData),
    .rx_valid    (rxValid),
    .tx_underrun (txUnderrun),
    .busy        (busy)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Per-negedge housekeeping: feed the tx buffer, log rx and underrun pulses
  task automatic service();
    if (txValid) begin
      void'(txq.pop_front());
      txValid = 1'b0;
    end
    if (txq.size() > 0 && txReady) begin
      txValid = 1'b1;
      txData  = txq[0];
    end
    if (rxValid) begin
      rxCount++;
      rxLog.push_back(rxData);
    end
    if (txUnderrun) underrunCount++;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      service();
    end
  endtask

  task automatic clearLogs();
    rxCount       = 0;
    underrunCount = 0;
    rxLog.delete();
  endtask

  // Master side of one character: MSB of m goes out first, MISO captured MSB-first
  task automatic applyStimulus(input logic [CL-1:0] m, input int nbits,
                               output logic [CL-1:0] cap);
    cap = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = m[CL-1-i];
        waitCycles(H);
        cap  = {cap[CL-2:0], misoOut};
        sclk = ~cpol;
        waitCycles(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = m[CL-1-i];
        waitCycles(H);
        cap  = {cap[CL-2:0], misoOut};
        sclk = cpol;
        waitCycles(H);
      end
    end
    waitCycles(H);
  endtask

  initial begin
    // Reset state
    waitCycles(3);
    checkOutput("rst_tx_ready", txReady, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_miso_oe", misoOe, 0);
    checkOutput("rst_miso_out", misoOut, 0);
    checkOutput("rst_rx_data", rxData, 8'h00);
    checkOutput("rst_rx_valid", rxValid, 0);
    checkOutput("rst_underrun", txUnderrun, 0);
    rstN = 1'b1;
    waitCycles(4);

    // Mode 0: tx 0xA5 preloaded, master sends 0x3C
    cpol = 0; cpha = 0; sclk = 0;
    clearLogs();
    txq.push_back(8'hA5);
    waitCycles(4);
    checkOutput("m0_tx_ready_full", txReady, 0);
    ssN = 0;
    waitCycles(6);
    checkOutput("m0_tx_ready_loaded", txReady, 1);
    checkOutput("m0_busy", busy, 1);
    checkOutput("m0_miso_oe", misoOe, 1);
    applyStimulus(8'h3C, 8, cap0);
    ssN = 1;
    waitCycles(8);
    checkOutput("m0_rx_count", rxCount, 1);
    checkOutput("m0_rx_data", rxData, 8'h3C);
    checkOutput("m0_miso", cap0, 8'hA5);
    checkOutput("m0_busy_end", busy, 0);

    // Mode 3: two back-to-back characters
    cpol = 1; cpha = 1; sclk = 1;
    waitCycles(8);
    clearLogs();
    txq.push_back(8'h12);
    txq.push_back(8'h34);
    waitCycles(4);
    ssN = 0;
    waitCycles(6);
    applyStimulus(8'h81, 8, cap0);
    applyStimulus(8'h7E, 8, cap1);
    ssN = 1;
    waitCycles(8);
    checkOutput("m3_rx_count", rxCount, 2);
    checkOutput("m3_rx0", (rxLog.size() > 0) ? rxLog[0] : 8'hxx, 8'h81);
    checkOutput("m3_rx1", (rxLog.size() > 1) ? rxLog[1] : 8'hxx, 8'h7E);
    checkOutput("m3_miso0", cap0, 8'h12);
    checkOutput("m3_miso1", cap1, 8'h34);
    checkOutput("m3_underruns", underrunCount, 0);

    // Mode 1 with an empty transmit buffer
    cpol = 0; cpha = 1; sclk = 0;
    waitCycles(8);
    clearLogs();
    ssN = 0;
    waitCycles(6);
    applyStimulus(8'hC3, 8, cap0);
    ssN = 1;
    waitCycles(8);
    checkOutput("m1_underruns", underrunCount, 1);
    checkOutput("m1_miso", cap0, 8'h00);
    checkOutput("m1_rx_count", rxCount, 1);
    checkOutput("m1_rx_data", rxData, 8'hC3);

    // Deselect after 5 of 8 bits, then a full 0x55
    clearLogs();
    ssN = 0;
    waitCycles(6);
    applyStimulus(8'hFF, 5, cap0);
    ssN = 1;
    waitCycles(8);
    checkOutput("abort_rx_count", rxCount, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_miso_oe", misoOe, 0);
    checkOutput("abort_rx_data", rxData, 8'hC3);
    ssN = 0;
    waitCycles(6);
    applyStimulus(8'h55, 8, cap0);
    ssN = 1;
    waitCycles(8);
    checkOutput("after_abort_rx_count", rxCount, 1);
    checkOutput("after_abort_rx_data", rxData, 8'h55);

    // Reset mid-character in mode 0
    cpol = 0; cpha = 0; sclk = 0;
    waitCycles(8);
    clearLogs();
    txq.push_back(8'hFF);
    txq.push_back(8'hFF);
    waitCycles(4);
    ssN = 0;
    waitCycles(6);
    applyStimulus(8'hAA, 3, cap0);
    checkOutput("prerst_busy", busy, 1);
    checkOutput("prerst_miso", misoOut, 1);
    checkOutput("prerst_tx_ready", txReady, 0);
    rstN = 0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_miso_oe", misoOe, 0);
    checkOutput("midrst_miso", misoOut, 0);
    checkOutput("midrst_tx_ready", txReady, 1);
    checkOutput("midrst_rx_data", rxData, 8'h00);
    checkOutput("midrst_rx_valid", rxValid, 0);
    checkOutput("midrst_underrun", txUnderrun, 0);
    ssN = 1; cpol = 1; cpha = 0; sclk = 1; mosi = 0;
    waitCycles(4);
    rstN = 1;
    waitCycles(8);

    // Mode 2 after reset release
    clearLogs();
    ssN = 0;
    waitCycles(6);
    applyStimulus(8'hF0, 8, cap0);
    ssN = 1;
    waitCycles(8);
    checkOutput("m2_rx_count", rxCount, 1);
    checkOutput("m2_rx_data", rxData, 8'hF0);

    // Bit order: mode 0, MOSI 1 then seven 0s, tx 0x01
    cpol = 0; cpha = 0; sclk = 0;
    waitCycles(8);
    clearLogs();
    txq.push_back(8'h01);
    waitCycles(4);
    ssN = 0;
    waitCycles(6);
    applyStimulus(8'h80, 8, cap0);
    ssN = 1;
    waitCycles(8);
    checkOutput("order_rx_count", rxCount, 1);
`ifdef SPI_SLV_LSB_FIRST_EN
    checkOutput("lsb_rx_data", rxData, 8'h01);
    checkOutput("lsb_first_miso_bit", cap0[CL-1], 1);
    checkOutput("lsb_miso", cap0, 8'h80);
`else
    checkOutput("msb_rx_data", rxData, 8'h80);
    checkOutput("msb_first_miso_bit", cap0[CL-1], 0);
    checkOutput("msb_miso", cap0, 8'h01);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
